// File: rtl/axi_wresp_pkg.sv
// Shared constants and types for the AXI write-response arbiter.
package axi_wresp_pkg;

    localparam int AXI_ID_BITS  = 4;
    localparam int AXI_IDS_BITS = 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } wresp_state_e;

    typedef enum logic [1:0] {
        SL_S0 = 2'd0,
        SL_S1 = 2'd1,
        SL_DS = 2'd2
    } slave_e;

    // Round-robin successor; DS and the unused code 3 both wrap to S0.
    function automatic logic [1:0] next_slave(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant; search starts at ptr and wraps S0 -> S1 -> DS.
module rr_arbiter3
    import axi_wresp_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic [1:0] gnt_idx
);

    logic [1:0] ord0;
    logic [1:0] ord1;
    logic [1:0] ord2;

    assign ord0 = (ptr == 2'd3) ? 2'd0 : ptr;
    assign ord1 = next_slave(ord0);
    assign ord2 = next_slave(ord1);

    always_comb begin
        gnt     = 3'b000;
        gnt_idx = ord0;
        if (req[ord0]) begin
            gnt     = 3'b001 << ord0;
            gnt_idx = ord0;
        end else if (req[ord1]) begin
            gnt     = 3'b001 << ord1;
            gnt_idx = ord1;
        end else if (req[ord2]) begin
            gnt     = 3'b001 << ord2;
            gnt_idx = ord2;
        end
    end

endmodule

// File: rtl/wresp_arbiter.sv
// B-channel sequencer: round-robin capture of one slave response, then
// routing to the master named by the upper BID bits.
//   state | meaning
//   IDLE  | arbitrating; winner's BReady driven and response captured
//   SEND  | holding captured response on the selected master until BReady
module wresp_arbiter
    import axi_wresp_pkg::*;
#(
    parameter int ID_BITS     = AXI_ID_BITS,
    parameter int IDS_BITS    = AXI_IDS_BITS,
    parameter int STALL_LIMIT = 255
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [IDS_BITS-1:0] S0_BID,
    input  logic [1:0]          S0_BResp,
    input  logic                S0_BValid,
    output logic                S0_BReady,
    input  logic [IDS_BITS-1:0] S1_BID,
    input  logic [1:0]          S1_BResp,
    input  logic                S1_BValid,
    output logic                S1_BReady,
    input  logic [IDS_BITS-1:0] DS_BID,
    input  logic [1:0]          DS_BResp,
    input  logic                DS_BValid,
    output logic                DS_BReady,
    output logic [ID_BITS-1:0]  M0_BID,
    output logic [1:0]          M0_BResp,
    output logic                M0_BValid,
    input  logic                M0_BReady,
    output logic [ID_BITS-1:0]  M1_BID,
    output logic [1:0]          M1_BResp,
    output logic                M1_BValid,
    input  logic                M1_BReady,
    output logic                decode_err,
    output logic                stall_err
);

    localparam int DST_W = IDS_BITS - ID_BITS;
    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    wresp_state_e        state;
    logic [1:0]          ptr;
    logic [1:0]          win_idx;
    logic [IDS_BITS-1:0] cap_bid;
    logic [1:0]          cap_resp;
    logic [CNT_W-1:0]    stall_cnt;

    logic [2:0]          req;
    logic [2:0]          gnt;
    logic [1:0]          gnt_idx;
    logic [DST_W-1:0]    dst;
    logic                in_send;
    logic                grant;
    logic                to_m0;
    logic                to_m1;
    logic                bad_dst;
    logic                handshake;

    assign req = {DS_BValid, S1_BValid, S0_BValid};

    rr_arbiter3 u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Gating with rst keeps BReady low while reset is held, not just after it.
    assign grant     = (state == IDLE) && !rst && (gnt != 3'b000);
    assign S0_BReady = grant && gnt[0];
    assign S1_BReady = grant && gnt[1];
    assign DS_BReady = grant && gnt[2];

    assign in_send = (state == SEND);
    assign dst     = cap_bid[IDS_BITS-1:ID_BITS];
    assign to_m0   = in_send && (dst == DST_W'(0));
    assign to_m1   = in_send && (dst == DST_W'(1));
    assign bad_dst = in_send && (dst > DST_W'(1));

    assign M0_BValid  = to_m0;
    assign M1_BValid  = to_m1;
    assign M0_BID     = cap_bid[ID_BITS-1:0];
    assign M1_BID     = cap_bid[ID_BITS-1:0];
    assign M0_BResp   = cap_resp;
    assign M1_BResp   = cap_resp;
    assign decode_err = bad_dst;

    // An undecodable response completes on its own so it is dropped in one cycle.
    assign handshake = (to_m0 && M0_BReady) || (to_m1 && M1_BReady) || bad_dst;
    assign stall_err = (stall_cnt == CNT_W'(STALL_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= SL_S0;
            win_idx   <= SL_S0;
            cap_bid   <= '0;
            cap_resp  <= '0;
            stall_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant) begin
                state   <= SEND;
                win_idx <= gnt_idx;
                case (gnt_idx)
                    SL_S1: begin
                        cap_bid  <= S1_BID;
                        cap_resp <= S1_BResp;
                    end
                    SL_DS: begin
                        cap_bid  <= DS_BID;
                        cap_resp <= DS_BResp;
                    end
                    default: begin
                        cap_bid  <= S0_BID;
                        cap_resp <= S0_BResp;
                    end
                endcase
            end
        end else begin
            if (handshake) begin
                state     <= IDLE;
                ptr       <= next_slave(win_idx);
                stall_cnt <= '0;
            end else if (!stall_err) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wresp_arbiter.sv
// Directed bench for wresp_arbiter: stimulus pushes expected master responses,
// a negedge monitor pops and compares them on every master handshake/decode_err.
module tb_wresp_arbiter;
    import axi_wresp_pkg::*;

    typedef struct packed {
        logic [1:0] kind;   // 0 = M0, 1 = M1, 2 = decode error
        logic [3:0] bid;
        logic [1:0] resp;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] s_bid [3];
    logic [1:0] s_resp [3];
    logic [2:0] s_valid;
    logic       m0_ready;
    logic       m1_ready;

    logic       S0_BReady, S1_BReady, DS_BReady;
    logic [3:0] M0_BID, M1_BID;
    logic [1:0] M0_BResp, M1_BResp;
    logic       M0_BValid, M1_BValid;
    logic       decode_err, stall_err;

    exp_t exp_q[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   pend [3];
    logic [2:0] acc;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   fair_exp [4] = '{0, 1, 2, 0};

    wresp_arbiter #(
        .ID_BITS     (4),
        .IDS_BITS    (8),
        .STALL_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .S0_BID     (s_bid[0]),
        .S0_BResp   (s_resp[0]),
        .S0_BValid  (s_valid[0]),
        .S0_BReady  (S0_BReady),
        .S1_BID     (s_bid[1]),
        .S1_BResp   (s_resp[1]),
        .S1_BValid  (s_valid[1]),
        .S1_BReady  (S1_BReady),
        .DS_BID     (s_bid[2]),
        .DS_BResp   (s_resp[2]),
        .DS_BValid  (s_valid[2]),
        .DS_BReady  (DS_BReady),
        .M0_BID     (M0_BID),
        .M0_BResp   (M0_BResp),
        .M0_BValid  (M0_BValid),
        .M0_BReady  (m0_ready),
        .M1_BID     (M1_BID),
        .M1_BResp   (M1_BResp),
        .M1_BValid  (M1_BValid),
        .M1_BReady  (m1_ready),
        .decode_err (decode_err),
        .stall_err  (stall_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT presented a response with nothing expected", name);
    endtask

    // Rising edge + 1: retire slave responses accepted at the previous negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
                grant_log.push_back(i);
                grant_cyc.push_back(cyc);
                pend[i]--;
                if (pend[i] == 0) s_valid[i] = 1'b0;
            end
        end
        acc = 3'b000;
    endtask

    task automatic half();
        @(negedge clk);
        acc = {DS_BValid_s(), S1_BValid_s(), S0_BValid_s()};
    endtask

    function automatic logic S0_BValid_s();
        return s_valid[0] && S0_BReady;
    endfunction
    function automatic logic S1_BValid_s();
        return s_valid[1] && S1_BReady;
    endfunction
    function automatic logic DS_BValid_s();
        return s_valid[2] && DS_BReady;
    endfunction

    task automatic step();
        tick();
        half();
    endtask

    task automatic load(input int i, input logic [7:0] bid, input logic [1:0] resp, input int n);
        s_bid[i]   = bid;
        s_resp[i]  = resp;
        pend[i]    = n;
        s_valid[i] = 1'b1;
    endtask

    task automatic expect_rsp(input logic [1:0] kind, input logic [3:0] bid, input logic [1:0] resp);
        exp_t e;
        e.kind = kind;
        e.bid  = bid;
        e.resp = resp;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (pend[0] == 0 && pend[1] == 0 && pend[2] == 0 && !M0_BValid && !M1_BValid) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (M0_BValid && m0_ready) begin
                    if (exp_q.size() == 0) unexpected("m0_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("m0_route", 32'(e.kind), 32'd0);
                        chk("m0_bid", 32'(M0_BID), 32'(e.bid));
                        chk("m0_resp", 32'(M0_BResp), 32'(e.resp));
                    end
                end
                if (M1_BValid && m1_ready) begin
                    if (exp_q.size() == 0) unexpected("m1_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("m1_route", 32'(e.kind), 32'd1);
                        chk("m1_bid", 32'(M1_BID), 32'(e.bid));
                        chk("m1_resp", 32'(M1_BResp), 32'(e.resp));
                    end
                end
                if (decode_err) begin
                    if (exp_q.size() == 0) unexpected("decode_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("decode_route", 32'(e.kind), 32'd2);
                        chk("decode_no_valid", 32'({M0_BValid, M1_BValid}), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        acc         = 3'b000;
        rst         = 1'b1;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        s_valid     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            s_bid[i]  = 8'h00;
            s_resp[i] = 2'b00;
            pend[i]   = 0;
        end

        // Reset: a valid S1 must not see BReady while rst is held.
        s_valid[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_bready", 32'({S0_BReady, S1_BReady, DS_BReady}), 32'd0);
        chk("reset_outputs", 32'({M0_BValid, M1_BValid, M0_BID, M1_BID, M0_BResp, M1_BResp,
                                  decode_err, stall_err}), 32'd0);
        s_valid[1] = 1'b0;
        tick();
        rst = 1'b0;
        half();

        // Fairness: all three valid, masters ready; S0 carries two responses.
        tick();
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        grant_log.delete();
        grant_cyc.delete();
        load(0, 8'h01, OKAY, 2);
        load(1, 8'h12, EXOKAY, 1);
        load(2, 8'h03, SLVERR, 1);
        expect_rsp(2'd0, 4'h1, OKAY);
        expect_rsp(2'd1, 4'h2, EXOKAY);
        expect_rsp(2'd0, 4'h3, SLVERR);
        expect_rsp(2'd0, 4'h1, OKAY);
        half();
        wait_idle("fair_done", 20);
        chk("fair_count", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < grant_log.size()) chk("fair_order", 32'(grant_log[k]), 32'(fair_exp[k]));
        for (int k = 1; k < 4; k++)
            if (k < grant_cyc.size()) chk("fair_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd2);

        // Single response S1 -> M1, two-cycle round trip.
        tick();
        load(1, 8'h13, OKAY, 1);
        expect_rsp(2'd1, 4'h3, OKAY);
        half();
        chk("single_s1_bready", 32'(S1_BReady), 32'd1);
        chk("single_c0_m1_valid", 32'(M1_BValid), 32'd0);
        step();
        chk("single_c1_m1_valid", 32'(M1_BValid), 32'd1);
        chk("single_c1_m0_valid", 32'(M0_BValid), 32'd0);
        chk("single_c1_m1_bid", 32'(M1_BID), 32'h3);
        step();
        chk("single_c2_idle", 32'({M0_BValid, M1_BValid}), 32'd0);

        // Backpressure: DS -> M0 held 10 cycles.
        tick();
        m0_ready = 1'b0;
        grant_log.delete();
        load(2, 8'h05, SLVERR, 1);
        expect_rsp(2'd0, 4'h5, SLVERR);
        half();
        chk("bp_ds_bready", 32'(DS_BReady), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("bp_m0_valid", 32'(M0_BValid), 32'd1);
            chk("bp_m0_bid", 32'(M0_BID), 32'h5);
            chk("bp_m0_resp", 32'(M0_BResp), 32'(SLVERR));
            chk("bp_ds_bready_low", 32'(DS_BReady), 32'd0);
            chk("bp_stall_err", 32'(stall_err), 32'(k >= 5));
        end
        tick();
        m0_ready = 1'b1;
        half();
        chk("bp_hs_valid", 32'(M0_BValid), 32'd1);
        step();
        chk("bp_after_hs", 32'(M0_BValid), 32'd0);
        chk("bp_stall_clear", 32'(stall_err), 32'd0);
        chk("bp_ds_accepts", 32'(grant_log.size()), 32'd1);

        // Decode error: BID 8'h27 is dropped with a one-cycle pulse.
        tick();
        load(0, 8'h27, OKAY, 1);
        expect_rsp(2'd2, 4'h7, OKAY);
        half();
        chk("dec_s0_bready", 32'(S0_BReady), 32'd1);
        chk("dec_c0_err", 32'(decode_err), 32'd0);
        step();
        chk("dec_c1_err", 32'(decode_err), 32'd1);
        chk("dec_c1_valids", 32'({M0_BValid, M1_BValid}), 32'd0);
        step();
        chk("dec_c2_err", 32'(decode_err), 32'd0);
        chk("dec_c2_valids", 32'({M0_BValid, M1_BValid}), 32'd0);

        // Pointer now at S1: with S0 and S1 both valid, S1 goes first.
        tick();
        grant_log.delete();
        load(0, 8'h0C, SLVERR, 1);
        load(1, 8'h1A, EXOKAY, 1);
        expect_rsp(2'd1, 4'hA, EXOKAY);
        expect_rsp(2'd0, 4'hC, SLVERR);
        half();
        wait_idle("ptr_done", 12);
        chk("ptr_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("ptr_first", 32'(grant_log[0]), 32'd1);
            chk("ptr_second", 32'(grant_log[1]), 32'd0);
        end

        // Stall: M1 held off; stall_err from the 5th SEND cycle until after handshake.
        tick();
        m1_ready = 1'b0;
        load(1, 8'h16, EXOKAY, 1);
        expect_rsp(2'd1, 4'h6, EXOKAY);
        half();
        chk("stall_s1_bready", 32'(S1_BReady), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("stall_m1_valid", 32'(M1_BValid), 32'd1);
            chk("stall_err_level", 32'(stall_err), 32'(k >= 5));
        end
        tick();
        m1_ready = 1'b1;
        half();
        chk("stall_hs_err", 32'(stall_err), 32'd1);
        step();
        chk("stall_cleared", 32'(stall_err), 32'd0);
        chk("stall_m1_done", 32'(M1_BValid), 32'd0);

        // Reset in the middle of SEND.
        tick();
        m0_ready = 1'b0;
        load(0, 8'h08, SLVERR, 1);
        half();
        chk("rst_s0_bready", 32'(S0_BReady), 32'd1);
        step();
        chk("rst_m0_valid", 32'(M0_BValid), 32'd1);
        chk("rst_m0_bid", 32'(M0_BID), 32'h8);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({M0_BValid, M1_BValid, M0_BID, M1_BID, M0_BResp, M1_BResp,
                                      decode_err, stall_err, S0_BReady, S1_BReady, DS_BReady}), 32'd0);
        tick();
        grant_log.delete();
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        load(0, 8'h0D, OKAY, 1);
        load(1, 8'h1B, EXOKAY, 1);
        expect_rsp(2'd0, 4'hD, OKAY);
        expect_rsp(2'd1, 4'hB, EXOKAY);
        half();
        chk("rst_held_bready", 32'({S0_BReady, S1_BReady}), 32'd0);
        tick();
        rst = 1'b0;
        half();
        chk("rst_release_s0", 32'(S0_BReady), 32'd1);
        chk("rst_release_s1", 32'(S1_BReady), 32'd0);
        wait_idle("rst_done", 12);
        chk("rst_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("rst_first", 32'(grant_log[0]), 32'd0);
            chk("rst_second", 32'(grant_log[1]), 32'd1);
        end

        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wresp_arbiter.md
Name: wresp_arbiter

Overview:
- Sequences the AXI write-response (B) channel between the three response sources (S0, S1, DS) and the two masters (M0, M1).
- Arbitrates among valid slave responses using round-robin and captures the winner into a one-entry output register.
- Routes the captured response to the master selected by BID[7:4].
- Replaces priority-only combinational selection with fair, handshake-locked sequencing.

Parameters:
- ID_BITS, 4, master-side BID width.
- IDS_BITS, 8, slave-side BID width; upper IDS_BITS-ID_BITS bits carry the master index.
- STALL_LIMIT, 255, number of SEND cycles without master BReady before stall_err asserts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- S0_BID / S1_BID / DS_BID  in  IDS_BITS  slave response ID.
- S0_BResp / S1_BResp / DS_BResp  in  2  slave response code.
- S0_BValid / S1_BValid / DS_BValid  in  1  slave response valid.
- S0_BReady / S1_BReady / DS_BReady  out  1  slave response accept.
- M0_BID / M1_BID  out  ID_BITS  master response ID (slave BID[3:0]).
- M0_BResp / M1_BResp  out  2  master response code.
- M0_BValid / M1_BValid  out  1  master response valid.
- M0_BReady / M1_BReady  in  1  master response accept.
- decode_err  out  1  one-cycle pulse: captured BID[7:4] is not 0 or 1.
- stall_err  out  1  level: current SEND exceeded STALL_LIMIT cycles.

Behaviour:
- Reset (async, active-high):
  - State = IDLE; rr pointer = S0.
  - Output register cleared; stall counter = 0.
  - All BReady/BValid, decode_err and stall_err = 0.
- State IDLE:
  - Request vector = {DS,S1,S0}_BValid.
  - Round-robin search order starts at the pointer: S0 -> S1 -> DS -> S0.
  - On a winner: its BReady = 1 combinationally in the same cycle; all other BReady = 0; capture BID and BResp; move to SEND.
  - With no request: all BReady = 0; stay in IDLE.
- State SEND:
  - All slave BReady = 0.
  - Captured BID[7:4] = 0: M0_BValid = 1; M1_BValid = 0.
  - Captured BID[7:4] = 1: M1_BValid = 1; M0_BValid = 0.
  - Both M*_BID = captured BID[3:0]; both M*_BResp = captured BResp (data is don't-care on the non-valid master, but driven).
  - BValid and data stay stable until the selected M*_BReady = 1.
  - On handshake: return to IDLE; pointer = winner+1 (DS wraps to S0).
- Decode error (captured BID[7:4] >= 2):
  - No master BValid.
  - decode_err = 1 for exactly one cycle (the first SEND cycle).
  - Response is dropped; return to IDLE next cycle; pointer advances as on a normal handshake.
- Latency:
  - Slave handshake in cycle N; master BValid in cycle N+1.
  - Peak throughput is one response per 2 cycles (M BReady tied high).
- Stall counter:
  - Increments each SEND cycle without a handshake; saturates at STALL_LIMIT.
  - stall_err = (count == STALL_LIMIT).
  - Counter clears on handshake or reset. stall_err is informational and never drops the response.
- Simultaneous valids: only the winner is accepted; losers hold BValid per AXI and are served in later rounds.
- A slave deasserting BValid before acceptance is a protocol violation; the arbiter must not latch a non-valid source.
- M*_BReady asserted while the corresponding BValid = 0 is ignored.
- Reset mid-SEND: the response is lost, all outputs = 0 asynchronously, pointer = S0.

Decomposition:
- Package axi_wresp_pkg:
  - AXI_ID_BITS and AXI_IDS_BITS constants.
  - Response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - State enum {IDLE, SEND}.
  - Slave index enum {SL_S0, SL_S1, SL_DS}.
- Sub-module rr_arbiter3:
  - Inputs: 3-bit request, 2-bit pointer.
  - Outputs: one-hot grant, grant index.
  - Purely combinational; the pointer register lives in wresp_arbiter.

Test Plan:
- Single response: S1 valid, BID=8'h13, BResp=2'b00, M1_BReady=1 -> S1_BReady high in cycle 0; cycle 1 M1_BValid=1, M1_BID=4'h3, BResp=OKAY; M0_BValid=0; back to IDLE in cycle 2.
- Fairness: S0, S1, DS all valid continuously (IDs 8'h01/8'h12/8'h03), masters always ready -> grant order S0, S1, DS, S0; one grant every 2 cycles; no source is starved.
- Backpressure: DS valid with BID=8'h05, M0_BReady low for 10 cycles -> M0_BValid, M0_BID=4'h5 and BResp stay stable for 10 cycles; DS_BReady pulses once only; handshake in cycle 11.
- Decode error: S0 BID=8'h27 -> S0_BReady=1; decode_err pulses for 1 cycle; both M*_BValid stay 0; IDLE follows; pointer = S1.
- Stall: STALL_LIMIT=4, M1_BReady held low -> stall_err rises after the 4th SEND cycle and clears the cycle after the handshake.
- Reset mid-SEND: rst asserted while M0_BValid=1 -> all outputs 0 immediately; after release with S1 and S0 both valid, S0 wins.
